prb_bfp_compress: RTL and testbench

Per-PRB block-floating-point compressor directly upstream of `package_data`. It takes full-precision 16-bit I/Q resource elements (REs) from the beam-forming datapath and collects each PRB of 12 REs. For each PRB it picks one right-shift exponent, then emits 12 rounded and saturated 7-bit I/Q pairs plus the exponent. The output format is exactly what `package_data` consumes on `i_pkgN_data`, `i_pkgN_shift` and `i_pkgN_prb_idx`; one instance sits per package lane.

---
 rtl/pusch_pkg.sv | 48 ++++
 rtl/bfp_pingpong_buf.sv | 28 ++
 rtl/prb_bfp_compress.sv | 274 +++++++++++++++++++++++++++
 tb/tb_prb_bfp_compress.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pusch_pkg.sv
// Shared widths, read-FSM states and block-floating-point arithmetic helpers
// used by the per-PRB compressor. Ports: none (package).
package pusch_pkg;

  localparam int unsigned IW  = 16;
  localparam int unsigned OW  = 7;
  localparam int unsigned SW  = 4;
  localparam int unsigned NRE = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_BURST = 2'd2
  } bfp_st_e;

  // Right shift needed so the largest magnitude fits OW-1 magnitude bits.
  function automatic logic [SW-1:0] calc_shift(input logic [IW-2:0] m);
    logic [SW-1:0] bl;
    bl = '0;
    for (int i = 0; i < int'(IW) - 1; i++) begin
      if (m[i]) bl = SW'(i + 1);
    end
    return (bl > SW'(OW - 1)) ? SW'(bl - SW'(OW - 1)) : '0;
  endfunction

  // Round-half-up arithmetic shift at IW+1 bits, then saturate to OW bits.
  function automatic logic [OW-1:0] rnd_sat(input logic [IW-1:0] x,
                                            input logic [SW-1:0] sh);
    logic signed [IW:0] xe;
    logic signed [IW:0] rnd;
    logic signed [IW:0] y;
    logic signed [IW:0] hi;
    logic signed [IW:0] lo;
    xe  = $signed({x[IW-1], x});
    rnd = '0;
    if (sh != '0) rnd = $signed((IW + 1)'(1) << (sh - SW'(1)));
    y  = (xe + rnd) >>> sh;
    hi = $signed((IW + 1)'((1 << (OW - 1)) - 1));
    lo = ~hi;
    if (y > hi) begin
      y = hi;
    end else if (y < lo) begin
      y = lo;
    end
    return y[OW-1:0];
  endfunction

endpackage

// File: rtl/bfp_pingpong_buf.sv
// Two-bank register file holding one PRB per bank for the BFP compressor.
// Ports: clk; write port (wr_en, wr_bank, wr_addr, wr_data);
//        combinational read port (rd_bank, rd_addr -> rd_data).
module bfp_pingpong_buf #(
  parameter int unsigned DW  = 32,
  parameter int unsigned NRE = 12,
  parameter int unsigned AW  = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [2][NRE];

  // Sample storage only; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_bank][wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_bank][rd_addr];

endmodule

// File: rtl/prb_bfp_compress.sv
// Per-PRB block-floating-point compressor feeding package_data.
// Ports: clk, rst (sync, active-high); input RE stream i_vld/i_sop/i_eop with
// 16-bit signed i_data_i/i_data_q; output RE stream o_vld/o_sop/o_eop with
// o_prb_idx, o_data {I,Q} (7-bit each), o_shift exponent and o_err pulse.
module prb_bfp_compress #(
  parameter int unsigned IW  = pusch_pkg::IW,
  parameter int unsigned OW  = pusch_pkg::OW,
  parameter int unsigned SW  = pusch_pkg::SW,
  parameter int unsigned NRE = pusch_pkg::NRE,
  parameter int unsigned PW  = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_vld,
  input  logic            i_sop,
  input  logic            i_eop,
  input  logic [IW-1:0]   i_data_i,
  input  logic [IW-1:0]   i_data_q,
  output logic            o_vld,
  output logic            o_sop,
  output logic            o_eop,
  output logic [PW-1:0]   o_prb_idx,
  output logic [2*OW-1:0] o_data,
  output logic [SW-1:0]   o_shift,
  output logic            o_err
);

  import pusch_pkg::*;

  localparam int unsigned AW = $clog2(NRE);
  localparam int unsigned MW = IW - 1;
  localparam logic [AW-1:0] LAST = AW'(NRE - 1);

  // Write side state
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [MW-1:0] m_q, m_d;
  logic [PW-1:0] prb_cnt_q, prb_cnt_d;
  logic          first_q, first_d;

  // Completed PRB waiting for (or in) CALC
  logic [MW-1:0] c_m_q, c_m_d;
  logic [PW-1:0] c_idx_q, c_idx_d;
  logic          c_sop_q, c_sop_d;
  logic          c_eop_q, c_eop_d;
  logic          c_bank_q, c_bank_d;
  logic          pend_q, pend_d;

  // Read side state
  bfp_st_e       state_q, state_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [PW-1:0] b_idx_q, b_idx_d;
  logic          b_eop_q, b_eop_d;
  logic          b_bank_q, b_bank_d;

  // Registered outputs
  logic            o_vld_q, o_vld_d;
  logic            o_sop_q, o_sop_d;
  logic            o_eop_q, o_eop_d;
  logic [PW-1:0]   o_prb_idx_q, o_prb_idx_d;
  logic [2*OW-1:0] o_data_q, o_data_d;
  logic [SW-1:0]   o_shift_q, o_shift_d;
  logic            o_err_q, o_err_d;

  logic            done;
  logic            err;
  logic            wr_en;
  logic [AW-1:0]   base_cnt;
  logic [MW-1:0]   base_m;
  logic [PW-1:0]   base_prb;
  logic [MW-1:0]   mag;
  logic            rd_bank;
  logic [AW-1:0]   rd_addr;
  logic [2*IW-1:0] rd_data;
  logic [SW-1:0]   cur_shift;
  logic [2*OW-1:0] cnv_data;

  // Ones'-complement magnitude of the incoming I/Q pair, OR-ed together.
  assign mag = (i_data_i[MW-1:0] ^ {MW{i_data_i[IW-1]}})
             | (i_data_q[MW-1:0] ^ {MW{i_data_q[IW-1]}});

  // Write side: RE placement, exponent tracking, PRB completion and errors.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    m_d       = m_q;
    prb_cnt_d = prb_cnt_q;
    first_d   = first_q;
    c_m_d     = c_m_q;
    c_idx_d   = c_idx_q;
    c_sop_d   = c_sop_q;
    c_eop_d   = c_eop_q;
    c_bank_d  = c_bank_q;
    done      = 1'b0;
    err       = 1'b0;
    wr_en     = 1'b0;
    base_cnt  = wr_cnt_q;
    base_m    = m_q;
    base_prb  = prb_cnt_q;
    if (i_vld) begin
      // SOP abandons any partial PRB and restarts the symbol at this RE.
      if (i_sop) begin
        base_cnt = '0;
        base_m   = '0;
        base_prb = '0;
        first_d  = 1'b1;
        err      = (wr_cnt_q != '0);
      end
      prb_cnt_d = base_prb;
      if (i_eop && (base_cnt != LAST)) begin
        err      = 1'b1;
        wr_cnt_d = '0;
        m_d      = '0;
        first_d  = 1'b0;
      end else begin
        wr_en = 1'b1;
        if (base_cnt == LAST) begin
          done      = 1'b1;
          wr_cnt_d  = '0;
          m_d       = '0;
          wr_bank_d = ~wr_bank_q;
          prb_cnt_d = base_prb + PW'(1);
          first_d   = 1'b0;
          c_m_d     = base_m | mag;
          c_idx_d   = base_prb;
          c_sop_d   = first_q | i_sop;
          c_eop_d   = i_eop;
          c_bank_d  = wr_bank_q;
        end else begin
          wr_cnt_d = base_cnt + AW'(1);
          m_d      = base_m | mag;
        end
      end
    end
  end

  bfp_pingpong_buf #(
    .DW  (2 * IW),
    .NRE (NRE),
    .AW  (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (wr_bank_q),
    .wr_addr (base_cnt),
    .wr_data ({i_data_i, i_data_q}),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // CALC already emits RE 0 so that back-to-back PRBs leave no bubble.
  assign rd_bank   = (state_q == ST_CALC) ? c_bank_q : b_bank_q;
  assign rd_addr   = (state_q == ST_CALC) ? '0 : rd_cnt_q;
  assign cur_shift = (state_q == ST_CALC) ? calc_shift(c_m_q) : shift_q;
  assign cnv_data  = {rnd_sat(rd_data[2*IW-1:IW], cur_shift),
                      rnd_sat(rd_data[IW-1:0], cur_shift)};

  // Read FSM and output register next-state.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    rd_cnt_d    = rd_cnt_q;
    shift_d     = shift_q;
    b_idx_d     = b_idx_q;
    b_eop_d     = b_eop_q;
    b_bank_d    = b_bank_q;
    o_vld_d     = 1'b0;
    o_sop_d     = 1'b0;
    o_eop_d     = 1'b0;
    o_prb_idx_d = '0;
    o_data_d    = '0;
    o_shift_d   = '0;
    o_err_d     = err;
    if (done) pend_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (done) state_d = ST_CALC;
      end
      ST_CALC: begin
        shift_d     = cur_shift;
        b_idx_d     = c_idx_q;
        b_eop_d     = c_eop_q;
        b_bank_d    = c_bank_q;
        rd_cnt_d    = AW'(1);
        o_vld_d     = 1'b1;
        o_sop_d     = c_sop_q;
        o_prb_idx_d = c_idx_q;
        o_shift_d   = cur_shift;
        o_data_d    = cnv_data;
        state_d     = ST_BURST;
      end
      ST_BURST: begin
        o_vld_d     = 1'b1;
        o_prb_idx_d = b_idx_q;
        o_shift_d   = shift_q;
        o_data_d    = cnv_data;
        if (rd_cnt_q == LAST) begin
          o_eop_d = b_eop_q;
          state_d = (pend_q || done) ? ST_CALC : ST_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Entering CALC consumes the latched PRB.
    if (state_d == ST_CALC) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      m_q         <= '0;
      prb_cnt_q   <= '0;
      first_q     <= 1'b0;
      c_m_q       <= '0;
      c_idx_q     <= '0;
      c_sop_q     <= 1'b0;
      c_eop_q     <= 1'b0;
      c_bank_q    <= 1'b0;
      pend_q      <= 1'b0;
      state_q     <= ST_IDLE;
      rd_cnt_q    <= '0;
      shift_q     <= '0;
      b_idx_q     <= '0;
      b_eop_q     <= 1'b0;
      b_bank_q    <= 1'b0;
      o_vld_q     <= 1'b0;
      o_sop_q     <= 1'b0;
      o_eop_q     <= 1'b0;
      o_prb_idx_q <= '0;
      o_data_q    <= '0;
      o_shift_q   <= '0;
      o_err_q     <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      m_q         <= m_d;
      prb_cnt_q   <= prb_cnt_d;
      first_q     <= first_d;
      c_m_q       <= c_m_d;
      c_idx_q     <= c_idx_d;
      c_sop_q     <= c_sop_d;
      c_eop_q     <= c_eop_d;
      c_bank_q    <= c_bank_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      shift_q     <= shift_d;
      b_idx_q     <= b_idx_d;
      b_eop_q     <= b_eop_d;
      b_bank_q    <= b_bank_d;
      o_vld_q     <= o_vld_d;
      o_sop_q     <= o_sop_d;
      o_eop_q     <= o_eop_d;
      o_prb_idx_q <= o_prb_idx_d;
      o_data_q    <= o_data_d;
      o_shift_q   <= o_shift_d;
      o_err_q     <= o_err_d;
    end
  end

  assign o_vld     = o_vld_q;
  assign o_sop     = o_sop_q;
  assign o_eop     = o_eop_q;
  assign o_prb_idx = o_prb_idx_q;
  assign o_data    = o_data_q;
  assign o_shift   = o_shift_q;
  assign o_err     = o_err_q;

endmodule

// File: tb/tb_prb_bfp_compress.sv
// Self-checking bench for prb_bfp_compress: directed cases plus randomized
// symbols with input gaps, malformed symbols and a mid-burst reset, checked
// cycle by cycle against a PRB-level reference model.
module tb_prb_bfp_compress;

  localparam int NRE = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vld, i_sop, i_eop;
  logic [15:0] i_data_i, i_data_q;
  logic        o_vld, o_sop, o_eop, o_err;
  logic [8:0]  o_prb_idx;
  logic [13:0] o_data;
  logic [3:0]  o_shift;

  prb_bfp_compress dut (
    .clk       (clk),
    .rst       (rst),
    .i_vld     (i_vld),
    .i_sop     (i_sop),
    .i_eop     (i_eop),
    .i_data_i  (i_data_i),
    .i_data_q  (i_data_q),
    .o_vld     (o_vld),
    .o_sop     (o_sop),
    .o_eop     (o_eop),
    .o_prb_idx (o_prb_idx),
    .o_data    (o_data),
    .o_shift   (o_shift),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_d1 = 1'b1;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_d1 <= rst;
  end

  typedef struct {
    int          cyc;
    logic [13:0] data;
    bit          sop;
    bit          eop;
    int          idx;
    int          shift;
  } beat_t;

  beat_t exp_q[$];
  int    err_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (PRB granularity) ----------------
  int m_cnt = 0, m_prb = 0, m_last_start = -100;
  bit m_first = 0;
  int m_bi[NRE], m_bq[NRE];

  function automatic int ocm(input int x);
    return (x < 0) ? -x - 1 : x;
  endfunction

  function automatic int ref_shift(input int mx);
    int bl = 0;
    while (mx > 0) begin
      bl++;
      mx = mx / 2;
    end
    return (bl > 6) ? bl - 6 : 0;
  endfunction

  function automatic int ref_conv(input int x, input int sh);
    int r = (sh > 0) ? (1 << (sh - 1)) : 0;
    int y = (x + r) >>> sh;
    if (y > 63)  y = 63;
    if (y < -64) y = -64;
    return y;
  endfunction

  task automatic model_re(input bit sop, input bit eop, input int i, input int q, input int dc);
    bit          err;
    int          mx, sh, start;
    beat_t       b;
    logic [6:0]  yi, yq;
    err = 0;
    if (sop) begin
      if (m_cnt != 0) err = 1;
      m_cnt = 0; m_prb = 0; m_first = 1;
    end
    if (eop && m_cnt != NRE - 1) begin
      err = 1; m_cnt = 0; m_first = 0;
    end else begin
      m_bi[m_cnt] = i; m_bq[m_cnt] = q; m_cnt++;
      if (m_cnt == NRE) begin
        mx = 0;
        for (int k = 0; k < NRE; k++) begin
          if (ocm(m_bi[k]) > mx) mx = ocm(m_bi[k]);
          if (ocm(m_bq[k]) > mx) mx = ocm(m_bq[k]);
        end
        sh    = ref_shift(mx);
        start = dc + 2;
        if (start < m_last_start + NRE) start = m_last_start + NRE;
        m_last_start = start;
        for (int k = 0; k < NRE; k++) begin
          yi = 7'(ref_conv(m_bi[k], sh));
          yq = 7'(ref_conv(m_bq[k], sh));
          b.cyc = start + k; b.data = {yi, yq};
          b.sop = m_first && (k == 0); b.eop = eop && (k == NRE - 1);
          b.idx = m_prb; b.shift = sh;
          exp_q.push_back(b);
        end
        m_prb = (m_prb + 1) % 512; m_first = 0; m_cnt = 0;
      end
    end
    if (err) err_q.push_back(dc + 1);
  endtask

  // ---------------- output checker ----------------
  int          run = 0, last_run = 0, vld_total = 0;
  logic [13:0] cap_data;
  logic [3:0]  cap_shift;
  logic [8:0]  cap_idx;

  always @(negedge clk) begin : chk
    beat_t b;
    bit    exp_err;
    if (rst_d1) begin
      check_eq("rst_outputs", {o_vld, o_sop, o_eop, o_err, o_shift, o_prb_idx, o_data}, 0);
      run = 0;
    end else begin
      while (err_q.size() > 0 && err_q[0] < cyc) check_eq("err_sched", err_q.pop_front(), cyc);
      exp_err = (err_q.size() > 0 && err_q[0] == cyc);
      if (exp_err) void'(err_q.pop_front());
      check_eq("o_err", o_err, exp_err);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        b = exp_q.pop_front();
        check_eq("o_vld", o_vld, 1);
        check_eq("o_data", o_data, b.data);
        check_eq("o_sop", o_sop, b.sop);
        check_eq("o_eop", o_eop, b.eop);
        check_eq("o_prb_idx", o_prb_idx, b.idx);
        check_eq("o_shift", o_shift, b.shift);
      end else begin
        check_eq("o_vld_idle", o_vld, 0);
      end
      if (o_vld) begin
        run++; vld_total++;
        if (o_sop) begin
          cap_data = o_data; cap_shift = o_shift; cap_idx = o_prb_idx;
        end
      end else begin
        if (run > 0) last_run = run;
        run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit v, input bit sop, input bit eop, input int i, input int q);
    @(posedge clk); #1;
    i_vld = v; i_sop = sop; i_eop = eop;
    i_data_i = 16'(i); i_data_q = 16'(q);
    if (v) model_re(sop, eop, i, q, cyc);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send(0, 0, 0, 0, 0);
  endtask

  function automatic int rnd16(input int sc);
    int v = int'($signed(16'($urandom)));
    return v >>> sc;
  endfunction

  // nprb full PRBs; trunc>=0 appends trunc+1 REs ending in an early EOP.
  task automatic send_sym(input int nprb, input int gap, input int trunc);
    int total, sc;
    total = (trunc >= 0) ? nprb * NRE + trunc + 1 : nprb * NRE;
    sc = 0;
    for (int r = 0; r < total; r++) begin
      if (r % NRE == 0) sc = $urandom_range(0, 15);
      for (int g = 0; g < 8 && $urandom_range(0, 99) < gap; g++) send(0, 0, 0, 0, 0);
      send(1, r == 0, r == total - 1, rnd16(sc), rnd16(sc));
    end
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 400) begin
      idle(1); k++;
    end
    idle(3);
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1; i_vld = 0; i_sop = 0; i_eop = 0;
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    while (err_q.size() > 0 && err_q[$] > cyc) void'(err_q.pop_back());
    m_cnt = 0; m_prb = 0; m_first = 0; m_last_start = -100;
    repeat (n) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    int v0;
    rst = 1; i_vld = 0; i_sop = 0; i_eop = 0; i_data_i = '0; i_data_q = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    idle(2);

    // Single non-zero RE: shift 1, symmetric rounding of +/-100
    for (int r = 0; r < NRE; r++) send(1, r == 0, r == NRE - 1, (r == 0) ? 100 : 0, (r == 0) ? -100 : 0);
    drain();
    check_eq("t1_shift", cap_shift, 1);
    check_eq("t1_re0", cap_data, {7'd50, 7'h4E});

    // Full-scale: shift 9, I saturates, Q lands exactly on -64
    for (int r = 0; r < NRE; r++) send(1, r == 0, r == NRE - 1, 32767, -32768);
    drain();
    check_eq("t2_shift", cap_shift, 9);
    check_eq("t2_re0", cap_data, {7'h3F, 7'h40});

    // Zero PRB then a PRB that already fits in 7 bits
    for (int r = 0; r < 2 * NRE; r++) begin
      v0 = (r == NRE + 3) ? 63 : $urandom_range(0, 127) - 64;
      send(1, r == 0, r == 2 * NRE - 1, (r < NRE) ? 0 : v0, (r < NRE) ? 0 : $urandom_range(0, 127) - 64);
    end
    drain();
    check_eq("t3_zero_shift", cap_shift, 0);
    check_eq("t3_zero_data", cap_data, 0);

    // 132 contiguous PRBs: one unbroken output run
    send_sym(132, 0, -1);
    drain();
    check_eq("t4_run_len", last_run, 132 * NRE);

    // Early EOP: error pulse, no burst; next symbol restarts at index 0
    v0 = vld_total;
    send_sym(0, 0, 5);
    drain();
    check_eq("t5_no_burst", vld_total, v0);
    send_sym(1, 0, -1);
    drain();
    check_eq("t5_idx_restart", cap_idx, 0);

    // SOP in the middle of a PRB abandons it and starts a new symbol
    for (int r = 0; r < 5; r++) send(1, r == 0, 0, rnd16(4), rnd16(4));
    send_sym(2, 10, -1);
    drain();

    // Randomized symbols with gaps and occasional malformed endings
    for (int s = 0; s < 10; s++)
      send_sym($urandom_range(1, 4), $urandom_range(0, 40), ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : -1);
    drain();

    // Reset while a burst is running, then resume
    send_sym(3, 0, -1);
    idle(6);
    do_reset(2);
    idle(2);
    check_eq("post_rst_vld", o_vld, 0);
    for (int s = 0; s < 8; s++)
      send_sym($urandom_range(1, 4), $urandom_range(0, 40), ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : -1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
